instr_sequencer: RTL
====================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; single clock domain, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: fetch_req  out  1 (asserted to request an instruction); pc_out  out  10 (fetch address); instr_in  in  16 (fetched word); imem_valid  in  1 (instr_in valid this cycle).
REQ-004 SHALL have ports: ir_out  out  16, the latched instruction feeding the control unit.
REQ-005 SHALL have decoded-control inputs from the control unit: reg_write_en 1, flag_write_en 1, mem_read 1, mem_write 1, pc_sel 2, immediate 16, multi_cycle 1 (alu_op needs more than one cycle).
REQ-006 SHALL have ports: alu_start  out  1; alu_done  in  1.
REQ-007 SHALL have ports: mem_rd_q  out  1; mem_wr_q  out  1; mem_ready  in  1.
REQ-008 SHALL have ports: reg_we_q  out  1; flag_we_q  out  1 (gated writeback strobes).
REQ-009 SHALL have ports: halt_req  in  1; halted  out  1; stack_err  out  1 (sticky).
REQ-010 SHALL have parameter STACK_DEPTH, default 4: depth of the return-address stack.

Function
REQ-011 SHALL implement FSM states FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-012 FETCH SHALL sample halt_req first: if 1, go to HALT with fetch_req=0; otherwise assert fetch_req until imem_valid=1, then latch instr_in into ir_out and go to DECODE.
REQ-013 DECODE SHALL last exactly one cycle, then go to EXEC.
REQ-014 EXEC with multi_cycle=0 SHALL last one cycle; with multi_cycle=1 it SHALL pulse alu_start for the first EXEC cycle only, then hold until alu_done=1. alu_done in the alu_start cycle SHALL be accepted.
REQ-015 From EXEC the FSM SHALL go to MEM if mem_read or mem_write is 1, else to WB.
REQ-016 In MEM, mem_rd_q/mem_wr_q SHALL follow mem_read/mem_write and be held until mem_ready=1, then the FSM SHALL go to WB.
REQ-017 WB SHALL last one cycle, pulse reg_we_q=reg_write_en and flag_we_q=flag_write_en, update PC, and go to FETCH.
REQ-018 The PC update SHALL be: pc_sel 00 -> PC+1; 01 -> immediate[9:0]; 10 -> push PC+1, then PC=immediate[9:0]; 11 -> pop into PC. All arithmetic is 10-bit and wraps 1023 -> 0.
REQ-019 A push on a full stack SHALL still jump, discard the push, and set stack_err.
REQ-020 A pop on an empty stack SHALL take PC+1 and set stack_err.
REQ-021 Decoded inputs SHALL be sampled in the state that uses them; ir_out SHALL stay stable from DECODE through WB.
REQ-022 HALT SHALL assert halted, hold all strobes at 0, and return to FETCH the cycle after halt_req=0. PC is unchanged by a halt.
REQ-023 Minimum latency SHALL be 4 cycles per instruction (FETCH, DECODE, EXEC, WB), or 5 with MEM.

Reset
REQ-024 While rst=1, the block SHALL hold: state=FETCH; pc_out=0; ir_out=0; stack pointer=0 (empty); stack_err=0; halted=0; fetch_req, alu_start, mem_rd_q, mem_wr_q, reg_we_q, flag_we_q all 0.
REQ-025 Reset mid-operation, including during an outstanding ALU or memory wait, SHALL abandon the instruction with no writeback strobe. fetch_req SHALL rise on the first clock after rst falls.

Verification
REQ-026 ADD at PC 0, imem_valid immediate -> reg_we_q and flag_we_q pulse in cycle 4, pc_out=1, fetch_req reasserts in cycle 5.
REQ-027 MUL with multi_cycle=1 and alu_done 3 cycles after alu_start -> alu_start is exactly 1 cycle wide, WB follows alu_done by 1 cycle, total 7 cycles.
REQ-028 LDA with mem_ready delayed 2 cycles -> mem_rd_q held 3 cycles, reg_we_q pulses once, pc_out increments by 1.
REQ-029 JMP to 0x100 from PC 5, then RET -> pc_out=0x100, then pc_out=6. Five nested JMPs (stack depth 4) -> 5th jump taken, stack_err=1. RET on empty stack -> PC+1, stack_err=1.
REQ-030 BRZ with pc_sel=00 at PC 1023 -> pc_out=0. BRA with pc_sel=01, immediate=0x3FF -> pc_out=1023.
REQ-031 Assert rst during an EXEC wait -> all outputs are at reset values immediately. halt_req=1 in FETCH -> halted=1, no fetch_req until halt_req=0.

Source files
------------

// File: rtl/instr_sequencer_if.sv
// -----------------------------------------------------------------------------
// instr_sequencer_if
// Handshake bundle between the instruction sequencer and its datapath peers:
//   instruction fetch : fetch_req, pc_out (seq -> imem); instr_in, imem_valid
//   ALU handshake     : alu_start (seq -> alu); alu_done
//   memory handshake  : mem_rd_q, mem_wr_q (seq -> mem); mem_ready
// master = sequencer side, slave = the imem/alu/mem side.
// -----------------------------------------------------------------------------
interface instr_sequencer_if;
  logic        fetch_req;
  logic [9:0]  pc_out;
  logic [15:0] instr_in;
  logic        imem_valid;
  logic        alu_start;
  logic        alu_done;
  logic        mem_rd_q;
  logic        mem_wr_q;
  logic        mem_ready;

  modport master (
    output fetch_req, pc_out, alu_start, mem_rd_q, mem_wr_q,
    input  instr_in, imem_valid, alu_done, mem_ready
  );

  modport slave (
    input  fetch_req, pc_out, alu_start, mem_rd_q, mem_wr_q,
    output instr_in, imem_valid, alu_done, mem_ready
  );
endinterface

// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC -> [MEM] -> WB,
// plus HALT. Owns the PC and a small return-address stack.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   bus (master)      fetch / ALU / memory handshakes (see instr_sequencer_if)
//   reg_write_en, flag_write_en, mem_read, mem_write, pc_sel, immediate,
//   multi_cycle       decoded controls from the control unit
//   ir_out            latched instruction, stable from DECODE through WB
//   reg_we_q, flag_we_q  one-cycle writeback strobes in WB
//   halt_req/halted   halt request and status
//   stack_err         sticky return-stack overflow/underflow flag
// All outputs are registered; each output register is loaded from the value
// it must carry in the next state, so the decoded controls are read one cycle
// ahead of the state they affect (they are derived from ir_out and stable).
// -----------------------------------------------------------------------------
module instr_sequencer #(
  parameter int STACK_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  instr_sequencer_if.master  bus,
  input  logic               reg_write_en,
  input  logic               flag_write_en,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [1:0]         pc_sel,
  input  logic [15:0]        immediate,
  input  logic               multi_cycle,
  output logic [15:0]        ir_out,
  output logic               reg_we_q,
  output logic               flag_we_q,
  input  logic               halt_req,
  output logic               halted,
  output logic               stack_err
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_FULL  = SP_W'(STACK_DEPTH);
  localparam logic [SP_W-1:0] SP_EMPTY = {SP_W{1'b0}};

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  state_t            state_r, next_state_s;
  logic              fetch_req_r, alu_start_r, mem_rd_r, mem_wr_r;
  logic              reg_we_r, flag_we_r, halted_r, stack_err_r;
  logic              fetch_req_s, alu_start_s, mem_rd_s, mem_wr_s;
  logic              reg_we_s, flag_we_s, halted_s, ir_load_s;
  logic [15:0]       ir_r;
  logic [9:0]        pc_r, pc_next_s, pc_plus1_s;
  logic [SP_W-1:0]   sp_r, sp_next_s, sp_dec_s;
  logic [IDX_W-1:0]  push_idx_s, pop_idx_s;
  logic              push_en_s, err_set_s;
  logic [9:0]        stack_r [STACK_DEPTH];
  logic              unused_imm_s;

  // Only the low 10 immediate bits address instruction memory.
  assign unused_imm_s = ^immediate[15:10];

  assign pc_plus1_s = pc_r + 10'd1;
  assign sp_dec_s   = sp_r - SP_W'(1);
  assign push_idx_s = sp_r[IDX_W-1:0];
  assign pop_idx_s  = sp_dec_s[IDX_W-1:0];

  assign bus.fetch_req = fetch_req_r;
  assign bus.pc_out    = pc_r;
  assign bus.alu_start = alu_start_r;
  assign bus.mem_rd_q  = mem_rd_r;
  assign bus.mem_wr_q  = mem_wr_r;
  assign ir_out        = ir_r;
  assign reg_we_q      = reg_we_r;
  assign flag_we_q     = flag_we_r;
  assign halted        = halted_r;
  assign stack_err     = stack_err_r;

  // Next-state decode and next values of the registered control outputs.
  always_comb begin
    next_state_s = state_r;
    ir_load_s    = 1'b0;
    case (state_r)
      ST_FETCH: begin
        // halt_req has priority over a word arriving in the same cycle
        if (halt_req) begin
          next_state_s = ST_HALT;
        end else if (fetch_req_r && bus.imem_valid) begin
          next_state_s = ST_DECODE;
          ir_load_s    = 1'b1;
        end else begin
          next_state_s = ST_FETCH;
        end
      end
      ST_DECODE: next_state_s = ST_EXEC;
      ST_EXEC: begin
        // alu_done is honoured even in the alu_start cycle
        if (multi_cycle && !bus.alu_done) begin
          next_state_s = ST_EXEC;
        end else if (mem_read || mem_write) begin
          next_state_s = ST_MEM;
        end else begin
          next_state_s = ST_WB;
        end
      end
      ST_MEM: begin
        if (bus.mem_ready) begin
          next_state_s = ST_WB;
        end else begin
          next_state_s = ST_MEM;
        end
      end
      ST_WB: next_state_s = ST_FETCH;
      ST_HALT: begin
        if (halt_req) begin
          next_state_s = ST_HALT;
        end else begin
          next_state_s = ST_FETCH;
        end
      end
      default: next_state_s = ST_FETCH;
    endcase

    fetch_req_s = (next_state_s == ST_FETCH) && !halt_req;
    alu_start_s = (state_r == ST_DECODE) && multi_cycle;
    mem_rd_s    = (next_state_s == ST_MEM) && mem_read;
    mem_wr_s    = (next_state_s == ST_MEM) && mem_write;
    reg_we_s    = (next_state_s == ST_WB) && reg_write_en;
    flag_we_s   = (next_state_s == ST_WB) && flag_write_en;
    halted_s    = (next_state_s == ST_HALT);
  end

  // PC / return-stack update, applied only at the end of WB.
  always_comb begin
    pc_next_s = pc_r;
    sp_next_s = sp_r;
    push_en_s = 1'b0;
    err_set_s = 1'b0;
    if (state_r == ST_WB) begin
      case (pc_sel)
        2'b00: pc_next_s = pc_plus1_s;
        2'b01: pc_next_s = immediate[9:0];
        2'b10: begin
          // a call always jumps; on a full stack the return address is lost
          pc_next_s = immediate[9:0];
          if (sp_r == SP_FULL) begin
            err_set_s = 1'b1;
          end else begin
            push_en_s = 1'b1;
            sp_next_s = sp_r + SP_W'(1);
          end
        end
        2'b11: begin
          if (sp_r == SP_EMPTY) begin
            pc_next_s = pc_plus1_s;
            err_set_s = 1'b1;
          end else begin
            pc_next_s = stack_r[pop_idx_s];
            sp_next_s = sp_dec_s;
          end
        end
        default: pc_next_s = pc_plus1_s;
      endcase
    end else begin
      pc_next_s = pc_r;
    end
  end

  // FSM state, instruction register and registered strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_FETCH;
      ir_r        <= 16'h0000;
      fetch_req_r <= 1'b0;
      alu_start_r <= 1'b0;
      mem_rd_r    <= 1'b0;
      mem_wr_r    <= 1'b0;
      reg_we_r    <= 1'b0;
      flag_we_r   <= 1'b0;
      halted_r    <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      fetch_req_r <= fetch_req_s;
      alu_start_r <= alu_start_s;
      mem_rd_r    <= mem_rd_s;
      mem_wr_r    <= mem_wr_s;
      reg_we_r    <= reg_we_s;
      flag_we_r   <= flag_we_s;
      halted_r    <= halted_s;
      if (ir_load_s) begin
        ir_r <= bus.instr_in;
      end
    end
  end

  // Program counter, return stack and sticky stack error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r        <= 10'd0;
      sp_r        <= SP_EMPTY;
      stack_err_r <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_r[i] <= 10'd0;
      end
    end else begin
      pc_r        <= pc_next_s;
      sp_r        <= sp_next_s;
      stack_err_r <= stack_err_r | err_set_s;
      if (push_en_s) begin
        stack_r[push_idx_s] <= pc_plus1_s;
      end
    end
  end

endmodule
